// File: rtl/sdpram_fifo_ctrl.sv
// Stream FIFO controller for an external simple dual-port RAM (1-cycle read latency).
// Optional high-water-mark tracking is enabled with `define FIFO_CTRL_HWM_EN.
module sdpram_fifo_ctrl #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 3)
) (
    input  logic               CLK,
    input  logic               RST,
`ifdef FIFO_CTRL_HWM_EN
    input  logic               HWM_CLR,
    output logic [CW-1:0]      HWM,
`endif
    input  logic               S_VALID,
    output logic               S_READY,
    input  logic [WIDTH-1:0]   S_DATA,
    output logic               M_VALID,
    input  logic               M_READY,
    output logic [WIDTH-1:0]   M_DATA,
    output logic               MEM_WEN,
    output logic [AW-1:0]      MEM_WADDR,
    output logic [WIDTH-1:0]   MEM_WDATA,
    output logic [WIDTH/8-1:0] MEM_WSTRB,
    output logic               MEM_REN,
    output logic [AW-1:0]      MEM_RADDR,
    input  logic               MEM_RVALID,
    input  logic [WIDTH-1:0]   MEM_RDATA,
    output logic [CW-1:0]      COUNT,
    output logic               FULL,
    output logic               EMPTY
);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      ram_cnt;
    logic [AW:0]      ram_cnt_nxt;
    logic             inflight;
    logic [1:0]       occ;
    logic [1:0]       occ_nxt;
    logic [1:0]       pend;
    logic [WIDTH-1:0] obuf0;
    logic [WIDTH-1:0] obuf1;
    logic             m_valid;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             wr_fire;
    logic             rd_issue;
    logic             push;
    logic             pop;

    // Handshakes, read-issue decision and next-state counters
    always_comb begin
        wr_fire     = S_VALID & ~full;
        pop         = m_valid & M_READY;
        push        = inflight & MEM_RVALID;
        pend        = occ + {1'b0, inflight};
        // A read may only be issued if its result is guaranteed a slot in the output buffer.
        rd_issue    = (ram_cnt != (AW+1)'(0)) &
                      ((pend < 2'd2) | ((pend == 2'd2) & pop));
        ram_cnt_nxt = ram_cnt;
        occ_nxt     = occ;
        case ({wr_fire, rd_issue})
            2'b10:   ram_cnt_nxt = ram_cnt + (AW+1)'(1);
            2'b01:   ram_cnt_nxt = ram_cnt - (AW+1)'(1);
            default: ram_cnt_nxt = ram_cnt;
        endcase
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
        count_nxt = CW'(ram_cnt_nxt) + CW'(rd_issue) + CW'(occ_nxt);
    end

    // Pointers, counters and registered status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            m_valid  <= 1'b0;
            full     <= 1'b0;
            empty    <= 1'b1;
            count    <= '0;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + AW'(1);
            end else begin
                wptr <= wptr;
            end
            if (rd_issue) begin
                rptr <= rptr + AW'(1);
            end else begin
                rptr <= rptr;
            end
            ram_cnt  <= ram_cnt_nxt;
            inflight <= rd_issue;
            occ      <= occ_nxt;
            m_valid  <= (occ_nxt != 2'd0);
            full     <= (ram_cnt_nxt == (AW+1)'(DEPTH));
            empty    <= (count_nxt == CW'(0));
            count    <= count_nxt;
        end
    end

    // Two-entry output buffer; obuf0 is always the head presented downstream
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            obuf0 <= '0;
            obuf1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        obuf0 <= MEM_RDATA;
                    end else begin
                        obuf1 <= MEM_RDATA;
                    end
                end
                2'b01: obuf0 <= obuf1;
                2'b11: begin
                    if (occ == 2'd1) begin
                        obuf0 <= MEM_RDATA;
                    end else begin
                        obuf0 <= obuf1;
                        obuf1 <= MEM_RDATA;
                    end
                end
                default: begin
                    obuf0 <= obuf0;
                    obuf1 <= obuf1;
                end
            endcase
        end
    end

`ifdef FIFO_CTRL_HWM_EN
    logic [CW-1:0] hwm;

    // Peak occupancy since reset or the last clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hwm <= '0;
        end else if (HWM_CLR) begin
            hwm <= count;
        end else if (count > hwm) begin
            hwm <= count;
        end else begin
            hwm <= hwm;
        end
    end

    assign HWM = hwm;
`endif

    assign S_READY   = ~full;
    assign M_VALID   = m_valid;
    assign M_DATA    = obuf0;
    assign MEM_WEN   = wr_fire;
    assign MEM_WADDR = wptr;
    assign MEM_WDATA = S_DATA;
    assign MEM_WSTRB = '1;
    assign MEM_REN   = rd_issue;
    assign MEM_RADDR = rptr;
    assign COUNT     = count;
    assign FULL      = full;
    assign EMPTY     = empty;

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Self-checking bench for sdpram_fifo_ctrl (DEPTH=8, WIDTH=16) with a behavioural RAM
// and a per-cycle scoreboard; HWM checks are compiled in with FIFO_CTRL_HWM_EN.
module tb_sdpram_fifo_ctrl;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          S_VALID = 1'b0;
    logic          S_READY;
    logic [W-1:0]  S_DATA = '0;
    logic          M_VALID;
    logic          M_READY = 1'b0;
    logic [W-1:0]  M_DATA;
    logic          MEM_WEN;
    logic [AW-1:0] MEM_WADDR;
    logic [W-1:0]  MEM_WDATA;
    logic [W/8-1:0] MEM_WSTRB;
    logic          MEM_REN;
    logic [AW-1:0] MEM_RADDR;
    logic          ram_rv = 1'b0;
    logic [W-1:0]  ram_rd = '0;
    logic [CW-1:0] COUNT;
    logic          FULL;
    logic          EMPTY;
`ifdef FIFO_CTRL_HWM_EN
    logic          hwm_clr = 1'b0;
    logic [CW-1:0] hwm;
`endif

    sdpram_fifo_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RST(RST),
`ifdef FIFO_CTRL_HWM_EN
        .HWM_CLR(hwm_clr), .HWM(hwm),
`endif
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .MEM_WEN(MEM_WEN), .MEM_WADDR(MEM_WADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_WSTRB(MEM_WSTRB), .MEM_REN(MEM_REN), .MEM_RADDR(MEM_RADDR),
        .MEM_RVALID(ram_rv), .MEM_RDATA(ram_rd),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    // Behavioural SDPRAM: 1-cycle read latency with a valid strobe, never reset
    logic [W-1:0] mem [0:D-1];
    always @(posedge CLK) begin
        if (MEM_WEN) mem[MEM_WADDR] <= MEM_WDATA;
        ram_rv <= MEM_REN;
        ram_rd <= mem[MEM_RADDR];
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] sb [$];
    int ram_m, outst, n_acc, n_out, cyc, first_out, last_out, sent;
    logic [AW-1:0] wptr_m, rptr_m;
    logic hs_w, sv_n, mr_n;

    typedef struct {
        logic sv; logic [W-1:0] d; logic mr;
        logic srdy; logic mv; logic [W-1:0] md;
        logic wen; logic [AW-1:0] wa; logic ren; logic [AW-1:0] ra;
        logic [CW-1:0] cnt; logic emp;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_models();
        sb.delete();
        ram_m = 0; outst = 0; wptr_m = '0; rptr_m = '0;
    endtask

    // Compares the DUT against the reference counters for the current cycle, then updates them.
    task automatic monitor();
        int tot;
        tot = ram_m + outst;
        cyc++;
        check("count", 32'(COUNT), tot);
        check("empty", 32'(EMPTY), 32'(tot == 0));
        check("full", 32'(FULL), 32'(ram_m == D));
        check("s_ready", 32'(S_READY), 32'(ram_m != D));
        check("wen", 32'(MEM_WEN), 32'(S_VALID && ram_m != D));
        hs_w = MEM_WEN;
        if (MEM_REN) begin
            check("ren_nonempty", 32'(ram_m != 0), 32'd1);
            check("raddr", 32'(MEM_RADDR), 32'(rptr_m));
            rptr_m++; ram_m--; outst++;
        end
        if (MEM_WEN) begin
            check("waddr", 32'(MEM_WADDR), 32'(wptr_m));
            check("wdata", 32'(MEM_WDATA), 32'(S_DATA));
            sb.push_back(S_DATA);
            wptr_m++; ram_m++; n_acc++;
        end
        if (M_VALID && M_READY) begin
            if (sb.size() == 0) check("pop_nonempty", 32'd0, 32'd1);
            else check("m_data", 32'(M_DATA), 32'(sb.pop_front()));
            outst--; n_out++;
            if (n_out == 1) first_out = cyc;
            last_out = cyc;
        end
        check("occ_inflight", 32'(outst <= 2), 32'd1);
    endtask

    task automatic step(input logic sv, input logic [W-1:0] d, input logic mr);
        @(posedge CLK); #1;
        S_VALID = sv; S_DATA = d; M_READY = mr;
        @(negedge CLK);
        monitor();
    endtask

    task automatic do_reset();
        RST = 1'b1; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0;
        reset_models();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // sv d mr | srdy mv md | wen wa ren ra | cnt emp
        tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b1};
        tbl[1]  = '{1'b1, 16'h00A5, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 3'd0, 4'd0, 1'b1};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1, 1'b1, 3'd0, 4'd1, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1, 1'b0, 3'd1, 4'd1, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00A5, 1'b0, 3'd1, 1'b0, 3'd1, 4'd1, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1, 1'b0, 3'd1, 4'd0, 1'b1};
        tbl[6]  = '{1'b1, 16'h00B1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b0, 3'd1, 4'd0, 1'b1};
        tbl[7]  = '{1'b1, 16'h00B2, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b1, 3'd1, 4'd1, 1'b0};
        tbl[8]  = '{1'b1, 16'h00B3, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd2, 4'd2, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00B1, 1'b0, 3'd4, 1'b1, 3'd3, 4'd3, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00B2, 1'b0, 3'd4, 1'b0, 3'd4, 4'd2, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00B3, 1'b0, 3'd4, 1'b0, 3'd4, 4'd1, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd4, 1'b0, 3'd4, 4'd0, 1'b1};
        n_acc = 0; n_out = 0; cyc = 0; first_out = 0; last_out = 0; sent = 0;
        hs_w = 1'b0; sv_n = 1'b0; mr_n = 1'b0;

        // Reset values while reset is held
        #1 RST = 1'b1;
        reset_models();
        #1;
        check("rst_s_ready", 32'(S_READY), 32'd1);
        check("rst_m_valid", 32'(M_VALID), 32'd0);
        check("rst_m_data", 32'(M_DATA), 32'd0);
        check("rst_wen", 32'(MEM_WEN), 32'd0);
        check("rst_ren", 32'(MEM_REN), 32'd0);
        check("rst_waddr", 32'(MEM_WADDR), 32'd0);
        check("rst_raddr", 32'(MEM_RADDR), 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("wstrb", 32'(MEM_WSTRB), 32'h3);
`ifdef FIFO_CTRL_HWM_EN
        check("rst_hwm", 32'(hwm), 32'd0);
`endif
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b1);
            check("idle_empty", 32'(EMPTY), 32'd1);
            check("idle_ren", 32'(MEM_REN), 32'd0);
            check("idle_m_valid", 32'(M_VALID), 32'd0);
        end

        // Directed vectors: single word, then a three-word burst
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].sv, tbl[i].d, tbl[i].mr);
            check($sformatf("t%0d_s_ready", i), 32'(S_READY), 32'(tbl[i].srdy));
            check($sformatf("t%0d_m_valid", i), 32'(M_VALID), 32'(tbl[i].mv));
            if (tbl[i].mv) check($sformatf("t%0d_m_data", i), 32'(M_DATA), 32'(tbl[i].md));
            check($sformatf("t%0d_wen", i), 32'(MEM_WEN), 32'(tbl[i].wen));
            check($sformatf("t%0d_waddr", i), 32'(MEM_WADDR), 32'(tbl[i].wa));
            check($sformatf("t%0d_ren", i), 32'(MEM_REN), 32'(tbl[i].ren));
            check($sformatf("t%0d_raddr", i), 32'(MEM_RADDR), 32'(tbl[i].ra));
            check($sformatf("t%0d_count", i), 32'(COUNT), 32'(tbl[i].cnt));
            check($sformatf("t%0d_empty", i), 32'(EMPTY), 32'(tbl[i].emp));
        end

        // Streaming 1000 words with the sink always ready
        n_out = 0; sent = 0;
        for (int c = 0; c < 3000 && n_out < 1000; c++) begin
            step(sent < 1000, W'(sent), 1'b1);
            if (hs_w) sent++;
        end
        check("stream_count", n_out, 32'd1000);
        check("stream_gapless", last_out - first_out, 32'd999);

        // Fill with the sink stalled, then one pop frees exactly one slot
        do_reset();
        n_acc = 0;
        for (int c = 0; c < 20; c++) step(1'b1, W'(16'h0100 + n_acc), 1'b0);
        check("fill_accepted", n_acc, 32'd10);
        check("fill_count", 32'(COUNT), 32'd10);
        check("fill_full", 32'(FULL), 32'd1);
        check("fill_s_ready", 32'(S_READY), 32'd0);
        step(1'b1, W'(16'h0100 + n_acc), 1'b1);
        for (int c = 0; c < 4; c++) step(1'b1, W'(16'h0100 + n_acc), 1'b0);
        check("refill_accepted", n_acc, 32'd11);
        step(1'b0, '0, 1'b0);
        check("refill_count", 32'(COUNT), 32'd10);
        check("refill_full", 32'(FULL), 32'd1);
`ifdef FIFO_CTRL_HWM_EN
        check("fill_hwm", 32'(hwm), 32'd10);
`endif
        for (int c = 0; c < 40 && !EMPTY; c++) step(1'b0, '0, 1'b1);
        check("drain_empty", 32'(EMPTY), 32'd1);
        check("drain_sb", sb.size(), 32'd0);

        // Random valid/ready backpressure, 10000 words
        do_reset();
        n_out = 0; sent = 0; hs_w = 1'b0;
        for (int c = 0; c < 40000 && n_out < 10000; c++) begin
            if (S_VALID && !hs_w) sv_n = 1'b1;
            else sv_n = (sent < 10000) && ($urandom_range(0, 3) != 0);
            mr_n = ($urandom_range(0, 4) < 3);
            step(sv_n, W'(sent * 7 + 3), mr_n);
            if (hs_w) sent++;
        end
        check("rand_count", n_out, 32'd10000);

        // Reset with words buffered and a read in flight
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, W'(16'h00C0 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        check("pre_count", 32'(COUNT), 32'd4);
        check("pre_m_valid", 32'(M_VALID), 32'd1);
        step(1'b0, '0, 1'b1);
        check("pre_ren", 32'(MEM_REN), 32'd1);
        @(posedge CLK); #1;
        check("inflight_count", 32'(COUNT), 32'd3);
        RST = 1'b1;
        #1;
        check("async_m_valid", 32'(M_VALID), 32'd0);
        check("async_count", 32'(COUNT), 32'd0);
        check("async_empty", 32'(EMPTY), 32'd1);
        check("async_ren", 32'(MEM_REN), 32'd0);
        check("async_raddr", 32'(MEM_RADDR), 32'd0);
        check("async_waddr", 32'(MEM_WADDR), 32'd0);
        reset_models();
        #1 RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            check("stale_m_valid", 32'(M_VALID), 32'd0);
            check("stale_count", 32'(COUNT), 32'd0);
        end
`ifdef FIFO_CTRL_HWM_EN
        check("post_rst_hwm", 32'(hwm), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sdpram_fifo_ctrl.md
Name: sdpram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives the write and read ports of an external simple dual-port RAM, which must be configured with 1-cycle read latency and RVALID strobe. It presents valid/ready stream interfaces upstream and downstream. A 2-entry registered output buffer hides the RAM read latency, so the block sustains 1 word/cycle. It sits between stream producers/consumers and the team's SDPRAM instances.

Parameters:
WIDTH, 64, data width [bit]; multiple of 8.
DEPTH, 512, RAM rows; power of 2, >= 4.

Ports:
CLK  in  1  clock
RST  in  1  reset; asynchronous, active-high
S_VALID  in  1  upstream word valid
S_READY  out  1  upstream ready (= !FULL)
S_DATA  in  WIDTH  upstream word
M_VALID  out  1  downstream word valid (registered)
M_READY  in  1  downstream ready
M_DATA  out  WIDTH  downstream word (registered)
MEM_WEN  out  1  RAM write enable
MEM_WADDR  out  $clog2(DEPTH)  RAM write address
MEM_WDATA  out  WIDTH  RAM write data (= S_DATA)
MEM_WSTRB  out  WIDTH/8  RAM byte strobes; constant all-ones
MEM_REN  out  1  RAM read request
MEM_RADDR  out  $clog2(DEPTH)  RAM read address
MEM_RVALID  in  1  RAM read data strobe, 1 cycle after MEM_REN
MEM_RDATA  in  WIDTH  RAM read data
COUNT  out  $clog2(DEPTH+3)  words held: RAM + in-flight + output buffer
FULL  out  1  RAM section holds DEPTH words
EMPTY  out  1  COUNT == 0

Behaviour:
- Reset (async assert, sync release): wptr=rptr=0, ram_cnt=0, inflight=0, obuf occupancy=0. Outputs: S_READY=1, M_VALID=0, M_DATA=0, MEM_WEN=0, MEM_REN=0, MEM_WADDR/MEM_RADDR=0, COUNT=0, FULL=0, EMPTY=1.
- Write: MEM_WEN = S_VALID & S_READY (combinational), MEM_WADDR=wptr, MEM_WDATA=S_DATA. On handshake: wptr+1 (wraps DEPTH-1 -> 0), ram_cnt+1.
- Read issue: MEM_REN = (ram_cnt>0) & ((occ+inflight<2) | (occ+inflight==2 & M_VALID & M_READY)). ram_cnt is a registered value, so a read is issued only for a word written at a previous edge. MEM_RADDR=rptr. On issue: rptr+1 (wraps), ram_cnt-1, inflight set for the next cycle.
- Capture: when inflight & MEM_RVALID, MEM_RDATA is pushed into the output buffer. MEM_RVALID without inflight is ignored; this covers stale strobes after reset.
- Output buffer: 2-entry FIFO of registers; M_DATA/M_VALID are driven from the head. A pop happens on M_VALID & M_READY. A simultaneous push and pop keeps occupancy unchanged.
- Occupancy invariant: occ+inflight <= 2 at all times; the bench asserts it.
- Simultaneous write and read issue: ram_cnt unchanged, both pointers advance.
- Full: S_READY=0 when ram_cnt==DEPTH. Total capacity is DEPTH+2. A write in the same cycle as a read issue while full is not accepted, since S_READY is derived from registered ram_cnt.
- Empty-FIFO latency: S handshake at edge k -> MEM_REN high in cycle k..k+1 -> MEM_RVALID after edge k+1 -> M_VALID high after edge k+2.
- Throughput: with M_READY held high and a continuous source, one word per cycle after the initial latency.
- COUNT = ram_cnt + inflight + occ, updated every edge. FULL/EMPTY are derived from the registered counters.
- Reset mid-operation: all state is cleared immediately and data in flight is discarded. RAM contents are not cleared and are not relevant.

Optional Feature:
FIFO_CTRL_HWM_EN: when defined, adds input HWM_CLR (1) and output HWM ($clog2(DEPTH+3)). HWM is a register holding the maximum COUNT seen since reset or HWM_CLR; HWM_CLR loads the current COUNT. Reset value is 0. When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: all outputs hold their reset values; EMPTY=1, COUNT=0, MEM_REN=0 for 20 cycles with no S_VALID.
- Single word 0xA5 with M_READY=1: MEM_WEN at cycle 0, addr 0; MEM_REN cycle 1, addr 0; M_VALID with M_DATA=0xA5 in cycle 3 for one cycle; COUNT returns to 0.
- Streaming 1000 incrementing words, M_READY=1, DEPTH=8: output in order, no gaps after first word, MEM_WADDR/MEM_RADDR wrap 7 -> 0.
- Fill with M_READY=0, DEPTH=8: S_READY drops after 10 accepted words; COUNT=10, FULL=1. Then one pop -> one more write accepted after read refill; data order preserved.
- Random S_VALID/M_READY backpressure, 10k words: scoreboard matches, occ+inflight<=2 holds, no MEM_REN when ram_cnt==0.
- Assert RST while 3 words are buffered and one read is in flight: outputs return to reset values asynchronously; the MEM_RVALID pulse after release is ignored and M_VALID stays 0. With FIFO_CTRL_HWM_EN, HWM reads 0 after reset and 10 after the fill scenario.
